// File: rtl/mix_column_engine.sv
// mix_column_engine: AES (inverse) MixColumns over a 128-bit state,
// COLS_PER_CYCLE columns per clock, with a valid/ready handshake on each side.
module mix_column_engine #(
   parameter int COLS_PER_CYCLE = 1,
   parameter bit INV_EN = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic         in_inv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t st;
   logic [1:0] cnt, cnt_nxt;
   logic [127:0] work, nxt;
   logic inv, md;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
      logic [7:0] b2, b4, b8;
      b2 = xt(b);
      b4 = xt(b2);
      b8 = xt(b4);
      return (m[0] ? b : 8'h00) ^ (m[1] ? b2 : 8'h00) ^ (m[2] ? b4 : 8'h00) ^ (m[3] ? b8 : 8'h00);
   endfunction

   // coef holds one nibble per matrix position; row i uses it rotated right by i
   function automatic logic [31:0] mix(input logic [31:0] col, input logic inv_mode);
      logic [15:0] coef;
      logic [31:0] r;
      coef = inv_mode ? 16'hebd9 : 16'h2311;
      r = '0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            r[31-8*i -: 8] = r[31-8*i -: 8] ^ gmul(col[31-8*j -: 8], coef[15-4*((j-i+4)%4) -: 4]);
      return r;
   endfunction

   // tying the mode to INV_EN lets the inverse coefficients fold away when unused
   assign md = INV_EN && inv;
   assign out_state = work;

   always_comb begin
      cnt_nxt = cnt + 2'(COLS_PER_CYCLE);
      nxt = work;
      for (int k = 0; k < COLS_PER_CYCLE; k++)
         nxt[127-32*(int'(cnt)+k) -: 32] = mix(work[127-32*(int'(cnt)+k) -: 32], md);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= IDLE;
         cnt       <= '0;
         work      <= '0;
         inv       <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (st)
            IDLE: if (in_valid) begin
               work     <= in_state;
               inv      <= in_inv & INV_EN;
               cnt      <= '0;
               st       <= RUN;
               in_ready <= 1'b0;
               busy     <= 1'b1;
            end
            RUN: begin
               work <= nxt;
               cnt  <= cnt_nxt;
               if (cnt_nxt == 2'd0) begin
                  st        <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: if (out_ready) begin
               st        <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mix_column_engine.sv
// tb_mix_column_engine: golden vectors, handshake corner cases and a randomized
// round-trip scoreboard against a plain GF(2^8) arithmetic model, for 1/2/4 columns per cycle.
module tb_mix_column_engine;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [127:0] in_state = '0;
   logic in_inv = 1'b0;
   logic in_valid [3], out_ready [3], in_ready [3], out_valid [3], busy [3];
   logic [127:0] out_state [3];
   int vectors = 0, miscompares = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : gen
      mix_column_engine #(.COLS_PER_CYCLE(1 << g), .INV_EN(1'b1)) dut (
         .clk(clk), .rst_n(rst_n), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
         .in_state(in_state), .in_inv(in_inv), .out_valid(out_valid[g]),
         .out_ready(out_ready[g]), .out_state(out_state[g]), .busy(busy[g]));
   end

   typedef struct {
      int d;
      logic [127:0] din;
      logic md;
      logic [127:0] exp;
   } vec_t;
   vec_t tbl [12];

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      int p = 0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (int'(a) << i);
      for (int t = 14; t >= 8; t--) if (p[t]) p = p ^ (32'h11b << (t - 8));
      return p[7:0];
   endfunction

   function automatic logic [127:0] model_mix(input logic [127:0] s, input logic md);
      logic [7:0] base [4];
      logic [7:0] a [4];
      logic [7:0] o;
      logic [127:0] r;
      base = md ? '{8'h0e, 8'h0b, 8'h0d, 8'h09} : '{8'h02, 8'h03, 8'h01, 8'h01};
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int j = 0; j < 4; j++) a[j] = s[127-32*c-8*j -: 8];
         for (int rw = 0; rw < 4; rw++) begin
            o = 8'h00;
            for (int j = 0; j < 4; j++) o = o ^ gf_mul(a[j], base[(j-rw+4)%4]);
            r[127-32*c-8*rw -: 8] = o;
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run_block(input int d, input logic [127:0] din, input logic md,
                            input logic [127:0] exp, input string nm);
      int n = 0;
      while (!in_ready[d] && n < 50) begin cyc(); n++; end
      in_state = din;
      in_inv = md;
      in_valid[d] = 1'b1;
      cyc();
      in_valid[d] = 1'b0;
      in_state = rnd128();
      in_inv = ~md;
      n = 0;
      while (!out_valid[d] && n < 50) begin cyc(); n++; end
      chk({nm, " latency"}, 128'(n), 128'(4 >> d));
      chk({nm, " data"}, out_state[d], exp);
      chk({nm, " in_ready in done"}, 128'(in_ready[d]), 128'(0));
      out_ready[d] = 1'b1;
      cyc();
      out_ready[d] = 1'b0;
      chk({nm, " out_valid after handshake"}, 128'(out_valid[d]), 128'(0));
      chk({nm, " in_ready after handshake"}, 128'(in_ready[d]), 128'(1));
   endtask

   task automatic rand_test(input int d, input int nblk);
      logic [127:0] q [$];
      int got = 0;
      fork
         begin
            logic [127:0] x, fx, din, e;
            logic md, a;
            int n;
            for (int i = 0; i < nblk; i++) begin
               if (i % 2 == 0) begin
                  x = rnd128();
                  fx = model_mix(x, 1'b0);
                  din = x; md = 1'b0; e = fx;
               end else begin
                  din = fx; md = 1'b1; e = x;
               end
               repeat ($urandom_range(0, 2)) cyc();
               in_state = din;
               in_inv = md;
               in_valid[d] = 1'b1;
               n = 0;
               do begin a = in_ready[d]; cyc(); n++; end while (!a && n < 100);
               in_valid[d] = 1'b0;
               if (a) q.push_back(e);
               else begin
                  miscompares++;
                  $display("FAIL rand accept timeout dut%0d block %0d", d, i);
                  break;
               end
            end
         end
         begin
            logic pv;
            logic [127:0] pd;
            int n = 0;
            while (got < nblk && n < nblk * 40) begin
               out_ready[d] = 1'($urandom_range(0, 1));
               pv = out_valid[d] && out_ready[d];
               pd = out_state[d];
               cyc();
               n++;
               if (pv) begin
                  if (q.size() == 0) begin
                     vectors++;
                     miscompares++;
                     $display("FAIL rand duplicate dut%0d: got %h expected no output", d, pd);
                  end else chk($sformatf("rand dut%0d blk%0d", d, got), pd, q.pop_front());
                  got++;
               end
            end
            out_ready[d] = 1'b0;
         end
      join
      chk($sformatf("rand dut%0d block count", d), 128'(got), 128'(nblk));
      chk($sformatf("rand dut%0d leftover", d), 128'(q.size()), 128'(0));
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [127:0] A, B, F, D, DE, R;
      int n;
      A  = 128'hdb135345_f20a225c_01010101_2d26314c;
      B  = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
      F  = 128'hc6c6c6c6_01010101_c6c6c6c6_01010101;
      D  = 128'hd4d4d4d5_01010101_c6c6c6c6_01010101;
      DE = 128'hd5d5d7d6_01010101_c6c6c6c6_01010101;
      tbl[0]  = '{0, A, 1'b0, B};
      tbl[1]  = '{0, B, 1'b1, A};
      tbl[2]  = '{1, A, 1'b0, B};
      tbl[3]  = '{1, B, 1'b1, A};
      tbl[4]  = '{2, A, 1'b0, B};
      tbl[5]  = '{2, B, 1'b1, A};
      tbl[6]  = '{0, F, 1'b0, F};
      tbl[7]  = '{0, F, 1'b1, F};
      tbl[8]  = '{2, F, 1'b1, F};
      tbl[9]  = '{0, D, 1'b0, DE};
      tbl[10] = '{1, D, 1'b0, DE};
      tbl[11] = '{2, D, 1'b0, DE};
      for (int d = 0; d < 3; d++) begin in_valid[d] = 1'b0; out_ready[d] = 1'b0; end
      repeat (2) cyc();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset in_ready dut%0d", d), 128'(in_ready[d]), 128'(1));
         chk($sformatf("reset out_valid dut%0d", d), 128'(out_valid[d]), 128'(0));
         chk($sformatf("reset busy dut%0d", d), 128'(busy[d]), 128'(0));
         chk($sformatf("reset out_state dut%0d", d), out_state[d], 128'(0));
      end
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++)
         run_block(tbl[i].d, tbl[i].din, tbl[i].md, tbl[i].exp, $sformatf("vec%0d", i));

      // backpressure: result and flags hold, and a new request is ignored
      in_state = A; in_inv = 1'b0; in_valid[0] = 1'b1;
      cyc();
      in_valid[0] = 1'b0;
      n = 0;
      while (!out_valid[0] && n < 50) begin cyc(); n++; end
      in_state = D; in_valid[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk($sformatf("bp data c%0d", i), out_state[0], B);
         chk($sformatf("bp out_valid c%0d", i), 128'(out_valid[0]), 128'(1));
         chk($sformatf("bp in_ready c%0d", i), 128'(in_ready[0]), 128'(0));
      end
      in_valid[0] = 1'b0;
      out_ready[0] = 1'b1;
      cyc();
      out_ready[0] = 1'b0;
      cyc();
      chk("bp idle after release", 128'({busy[0], out_valid[0]}), 128'(0));

      // reset during RUN cycle 2 and during DONE
      for (int k = 0; k < 2; k++) begin
         in_state = A; in_inv = 1'b0; in_valid[0] = 1'b1;
         cyc();
         in_valid[0] = 1'b0;
         repeat (k == 0 ? 1 : 4) cyc();
         #2 rst_n = 1'b0;
         #1;
         chk($sformatf("abort%0d out_valid", k), 128'(out_valid[0]), 128'(0));
         chk($sformatf("abort%0d in_ready", k), 128'(in_ready[0]), 128'(1));
         chk($sformatf("abort%0d busy", k), 128'(busy[0]), 128'(0));
         #1 rst_n = 1'b1;
         n = 0;
         repeat (6) begin cyc(); n += int'(out_valid[0]); end
         chk($sformatf("abort%0d no partial result", k), 128'(n), 128'(0));
         R = rnd128();
         run_block(0, R, 1'b0, model_mix(R, 1'b0), $sformatf("after abort%0d", k));
      end

      for (int d = 0; d < 3; d++) rand_test(d, 2000);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
